sqrt_newton: RTL and testbench

- Sequential integer square-root unit using Newton-Raphson iteration, y(k+1) = (y(k) + x / y(k)) / 2.
- Division is done by an internal 32-cycle restoring divider.
- Accepts a signed 32-bit operand on a start pulse and returns floor(sqrt(x)) with done/error status.
- Used as a multi-cycle arithmetic coprocessor behind a simple start/done handshake.

---
 rtl/sqrt_newton.sv | 167 ++++++++++++++++
 tb/tb_sqrt_newton.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sqrt_newton.sv
// ============================================================================
//  sqrt_newton : integer square root by Newton-Raphson with a restoring divider
//  Rev 1.0
// ============================================================================
`default_nettype none

module sqrt_newton #(
  parameter int MAX_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic        done,
  output logic        error
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] C_MAX_ITER = ITER_W'(MAX_ITER);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_DIV    = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [31:0]       x_q, x_d;
  logic [31:0]       g_q, g_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [31:0]       y_q, y_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [4:0]  w_msb;
  logic [4:0]  w_shamt;
  logic [32:0] w_rem_sh;
  logic        w_rem_ge;
  logic [31:0] w_next_g;
  logic        w_step;

  always_comb begin
    w_msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x_q[i]) w_msb = 5'(i);
    end
  end

  // Starting at 2^(floor(msb/2)+1) keeps the guess strictly above sqrt(x),
  // so the iteration descends monotonically and stops on the first non-decrease.
  assign w_shamt  = (w_msb >> 1) + 5'd1;
  assign w_rem_sh = {rem_q, quo_q[31]};
  assign w_rem_ge = (w_rem_sh >= {1'b0, g_q});
  assign w_next_g = 32'(({1'b0, g_q} + {1'b0, quo_q}) >> 1);
  assign w_step   = (w_next_g < g_q) && (iter_q < C_MAX_ITER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      y_q     <= y_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CHECK;
      ST_CHECK:  state_d = (x_q[31] || (x_q == 32'd0)) ? ST_IDLE : ST_INIT;
      ST_INIT:   state_d = ST_DIV;
      ST_DIV:    if (cnt_q == 5'd31) state_d = ST_UPDATE;
      ST_UPDATE: state_d = w_step ? ST_DIV : ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    g_d     = g_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    y_d     = y_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (x_q[31]) begin
          y_d     = '0;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else if (x_q == 32'd0) begin
          y_d     = '0;
          error_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_INIT: begin
        g_d    = 32'd1 << w_shamt;
        iter_d = '0;
        rem_d  = '0;
        quo_d  = x_q;
        cnt_d  = '0;
      end
      ST_DIV: begin
        // Dividend bits shift out of quo's MSB while quotient bits fill its LSB.
        quo_d = {quo_q[30:0], w_rem_ge};
        rem_d = w_rem_ge ? 32'(w_rem_sh - {1'b0, g_q}) : w_rem_sh[31:0];
        cnt_d = cnt_q + 5'd1;
      end
      ST_UPDATE: begin
        if (w_step) begin
          g_d    = w_next_g;
          iter_d = iter_q + ITER_W'(1);
          rem_d  = '0;
          quo_d  = x_q;
          cnt_d  = '0;
        end
      end
      ST_FINISH: begin
        y_d     = g_q;
        error_d = 1'b0;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign y     = y_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_newton.sv
// ============================================================================
//  tb_sqrt_newton : scoreboard bench for sqrt_newton
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sqrt_newton;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_s = '0;
  logic [31:0] y_s;
  logic        done_s;
  logic        error_s;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] y;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  sqrt_newton #(.MAX_ITER(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x_s),
    .y     (y_s),
    .done  (done_s),
    .error (error_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bit-by-bit integer square root used as the reference model.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
    end
    return r;
  endfunction

  task automatic launch(input logic [31:0] v);
    exp_t e;
    e.err = v[31];
    e.y   = v[31] ? 32'd0 : ref_sqrt(v);
    exp_q.push_back(e);
    @(negedge clk);
    x_s   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_clr", {31'd0, done_s}, 32'd0);
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    for (int c = 0; c < 400 && !done_s; c++) @(negedge clk);
    chk({tag, "_timeout"}, {31'd0, done_s}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_y"}, y_s, e.y);
      chk({tag, "_err"}, {31'd0, error_s}, {31'd0, e.err});
    end
  endtask

  initial begin
    logic [31:0] bvals [7];
    logic [31:0] rv;
    bvals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16, 32'h7FFF_FFFF};

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_y", y_s, 32'd0);
    chk("rst_done", {31'd0, done_s}, 32'd0);
    chk("rst_err", {31'd0, error_s}, 32'd0);

    launch(32'd25);
    finish_op("x25");
    repeat (5) @(negedge clk);
    chk("x25_sticky", {31'd0, done_s}, 32'd1);
    chk("x25_hold_y", y_s, 32'd5);

    // Zero operand: done must rise on the edge after the start edge.
    launch(32'd0);
    chk("x0_early", {31'd0, done_s}, 32'd0);
    @(negedge clk);
    chk("x0_timing", {31'd0, done_s}, 32'd1);
    finish_op("x0");

    launch(32'hFFFF_FFF7);
    chk("neg_early", {31'd0, done_s}, 32'd0);
    @(negedge clk);
    chk("neg_timing", {31'd0, done_s}, 32'd1);
    finish_op("neg9");

    launch(32'd16);
    chk("err_clr", {31'd0, error_s}, 32'd0);
    finish_op("after_neg");

    for (int i = 0; i < 7; i++) begin
      launch(bvals[i]);
      finish_op($sformatf("bnd%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      rv = $urandom() & 32'h7FFF_FFFF;
      launch(rv);
      finish_op($sformatf("rnd%0d", i));
    end

    // A second start mid-operation must be ignored.
    launch(32'd144);
    repeat (10) @(negedge clk);
    x_s   = 32'd49;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_s   = 32'd9999;
    finish_op("restart_ign");

    launch(32'd1000);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    chk("midrst_y", y_s, 32'd0);
    chk("midrst_done", {31'd0, done_s}, 32'd0);
    chk("midrst_err", {31'd0, error_s}, 32'd0);
    repeat (60) @(negedge clk);
    chk("midrst_abort", {31'd0, done_s}, 32'd0);
    launch(32'd100);
    finish_op("x100");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
